// File: rtl/osc_sched_pkg.sv
// Shared definitions for the oscillator slot scheduler: slot geometry,
// scheduler state encoding and the first-slot helper.
package osc_sched_pkg;

  localparam int VOICES   = 8;
  localparam int V_WIDTH  = 3;
  localparam int O_WIDTH  = 2;
  localparam int OE_WIDTH = 1;
  localparam int E_WIDTH  = O_WIDTH + OE_WIDTH;
  localparam int SLOTS    = VOICES << E_WIDTH;
  localparam int X_WIDTH  = V_WIDTH + E_WIDTH;

  // Bit positions of the voice and oscillator fields inside xxxx.
  localparam int VX_LSB = E_WIDTH;
  localparam int OX_LSB = OE_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } sched_state_e;

  // Slot index of the first oscillator/env sub-slot of voice v.
  function automatic logic [X_WIDTH-1:0] slot_first(input logic [V_WIDTH-1:0] v);
    return {v, {E_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/osc_restart_queue.sv
// Per-voice accumulator restart queue: holds pending note-on restarts and
// opens a one-voice-window clear pulse when that voice's first slot comes up.
module osc_restart_queue
  import osc_sched_pkg::*;
(
  input  logic               sCLK_XVXOSC,
  input  logic               reset_reg,
  input  logic               req_valid,
  input  logic [V_WIDTH-1:0] req_voice,
  output logic               req_ready,
  input  logic               slot_adv,
  input  logic [X_WIDTH-1:0] slot_cur,
  input  logic [X_WIDTH-1:0] slot_nxt,
  output logic [VOICES-1:0]  accum_zero
);

  logic [VOICES-1:0]  pending;
  logic [VOICES-1:0]  set_mask;
  logic [VOICES-1:0]  apply_mask;
  logic [V_WIDTH-1:0] vx_nxt;
  logic               leaving;

  assign vx_nxt  = slot_nxt[X_WIDTH-1:VX_LSB];
  assign leaving = &slot_cur[E_WIDTH-1:0];

  // A voice stalls while a restart for it is queued or its window is open.
  assign req_ready = !reset_reg && !pending[req_voice] && !accum_zero[req_voice];

  // Decode accepted requests and the voice whose window opens on this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    set_mask   = '0;
    apply_mask = '0;
    if (req_valid && req_ready)
      set_mask[req_voice] = 1'b1;
    if (slot_adv && (slot_nxt == slot_first(vx_nxt)) && pending[vx_nxt])
      apply_mask[vx_nxt] = 1'b1;
  end

  // Pending mask and open windows; a window closes when its voice's last sub-slot ends.
  always_ff @(posedge sCLK_XVXOSC) begin
    if (reset_reg) begin
      pending    <= '0;
      accum_zero <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      pending    <= (pending & ~apply_mask) | set_mask;
      accum_zero <= leaving ? apply_mask : (accum_zero | apply_mask);
    end
  end

endmodule

// File: rtl/osc_slot_sched.sv
// Slot scheduler for the shared oscillator datapath: steps xxxx through
// every voice/osc/env slot and drives per-voice accumulator restarts.
// Optional status counters are built when OSC_SCHED_STATUS_EN is defined.
module osc_slot_sched
  import osc_sched_pkg::*;
(
  input  logic               sCLK_XVXOSC,
  input  logic               reset_reg,
  input  logic               run_req,
  input  logic               rst_req_valid,
  input  logic [V_WIDTH-1:0] rst_req_voice,
  output logic               rst_req_ready,
  output logic [X_WIDTH-1:0] xxxx,
  output logic               frame_start,
  output logic [VOICES-1:0]  osc_accum_zero,
  output logic               running
`ifdef OSC_SCHED_STATUS_EN
  ,
  output logic [15:0]        frame_count,
  output logic [15:0]        stall_count
`endif
);

  localparam logic [X_WIDTH-1:0] LAST_SLOT = X_WIDTH'(SLOTS - 1);

  sched_state_e       state;
  sched_state_e       state_nxt;
  logic [X_WIDTH-1:0] xxxx_nxt;

  // Next state and slot: STOP only falls back to IDLE at the frame boundary.
  always_comb begin
    state_nxt = state;
    xxxx_nxt  = xxxx + X_WIDTH'(1);
    unique case (state)
      IDLE: begin
        xxxx_nxt = '0;
        if (run_req) state_nxt = RUN;
      end
      RUN: begin
        if (!run_req) state_nxt = STOP;
      end
      STOP: begin
        if (run_req)                state_nxt = RUN;
        else if (xxxx == LAST_SLOT) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        xxxx_nxt  = '0;
      end
    endcase
  end

  // Registered scheduler state and slot outputs.
  always_ff @(posedge sCLK_XVXOSC) begin
    if (reset_reg) begin
      state       <= IDLE;
      xxxx        <= '0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_nxt;
      xxxx        <= xxxx_nxt;
      frame_start <= (state_nxt != IDLE) && (xxxx_nxt == '0);
      running     <= (state_nxt != IDLE);
    end
  end

  osc_restart_queue u_queue (
    .sCLK_XVXOSC (sCLK_XVXOSC),
    .reset_reg   (reset_reg),
    .req_valid   (rst_req_valid),
    .req_voice   (rst_req_voice),
    .req_ready   (rst_req_ready),
    .slot_adv    (state_nxt != IDLE),
    .slot_cur    (xxxx),
    .slot_nxt    (xxxx_nxt),
    .accum_zero  (osc_accum_zero)
  );

`ifdef OSC_SCHED_STATUS_EN
  // Frame counter wraps; stall counter saturates.
  always_ff @(posedge sCLK_XVXOSC) begin
    if (reset_reg) begin
      frame_count <= '0;
      stall_count <= '0;
    end else begin
      if (frame_start)
        frame_count <= frame_count + 16'd1;
      if (rst_req_valid && !rst_req_ready && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_osc_slot_sched.sv
// Randomized scoreboard bench for osc_slot_sched against a frame-level model.
module tb_osc_slot_sched;

  logic       sCLK_XVXOSC;
  logic       reset_reg;
  logic       run_req;
  logic       rst_req_valid;
  logic [2:0] rst_req_voice;
  logic       rst_req_ready;
  logic [5:0] xxxx;
  logic       frame_start;
  logic [7:0] osc_accum_zero;
  logic       running;
`ifdef OSC_SCHED_STATUS_EN
  logic [15:0] frame_count;
  logic [15:0] stall_count;
`endif

  osc_slot_sched dut (
    .sCLK_XVXOSC    (sCLK_XVXOSC),
    .reset_reg      (reset_reg),
    .run_req        (run_req),
    .rst_req_valid  (rst_req_valid),
    .rst_req_voice  (rst_req_voice),
    .rst_req_ready  (rst_req_ready),
    .xxxx           (xxxx),
    .frame_start    (frame_start),
    .osc_accum_zero (osc_accum_zero),
    .running        (running)
`ifdef OSC_SCHED_STATUS_EN
    ,
    .frame_count    (frame_count),
    .stall_count    (stall_count)
`endif
  );

  initial sCLK_XVXOSC = 1'b0;
  always #5 sCLK_XVXOSC = ~sCLK_XVXOSC;

  typedef struct {
    int          cyc;
    logic [5:0]  slot;
    logic        fs;
    logic [7:0]  az;
    logic        run;
    logic        rdy;
    logic [15:0] fc;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: mode 0=idle 1=run 2=stop, slot counter, pending set,
  // and the single voice whose restart window is currently open (-1: none).
  int mode;
  int slot;
  bit pend [8];
  int win;
  int m_fc;
  int m_sc;
  bit last_fs;
  bit last_rdy;

  task automatic model_step(input bit p_rst, input bit p_run, input bit p_valid, input int p_voice);
    bit acc;
    acc = p_valid && last_rdy;
    if (p_rst) begin
      mode = 0; slot = 0; win = -1; m_fc = 0; m_sc = 0;
      for (int i = 0; i < 8; i++) pend[i] = 0;
      return;
    end
    if (last_fs) m_fc = (m_fc + 1) % 65536;
    if (p_valid && !last_rdy && m_sc < 65535) m_sc++;
    case (mode)
      0: begin
        slot = 0;
        if (p_run) mode = 1;
      end
      1: begin
        slot = (slot + 1) % 64;
        if (!p_run) mode = 2;
      end
      default: begin
        if (p_run) begin
          mode = 1; slot = (slot + 1) % 64;
        end else if (slot == 63) begin
          mode = 0; slot = 0;
        end else begin
          slot++;
        end
      end
    endcase
    if (win >= 0 && (mode == 0 || slot / 8 != win)) win = -1;
    if (mode != 0 && slot % 8 == 0 && pend[slot / 8]) begin
      win = slot / 8;
      pend[slot / 8] = 0;
    end
    if (acc) pend[p_voice] = 1;
  endtask

  // Stimulus: drive inputs after each edge, advance the model, queue expectations.
  initial begin
    exp_t e;
    bit   p_rst, p_run, p_valid;
    int   p_voice;
    int   n_cycles;
    n_cycles = 4000;
    mode = 0; slot = 0; win = -1; m_fc = 0; m_sc = 0;
    last_fs = 0; last_rdy = 0;
    for (int i = 0; i < 8; i++) pend[i] = 0;
    reset_reg = 1'b1; run_req = 1'b0; rst_req_valid = 1'b0; rst_req_voice = '0;

    for (int c = 0; c < n_cycles; c++) begin
      @(posedge sCLK_XVXOSC);
      #1;
      p_rst = reset_reg; p_run = run_req; p_valid = rst_req_valid; p_voice = int'(rst_req_voice);
      model_step(p_rst, p_run, p_valid, p_voice);

      reset_reg = (c < 2) || ($urandom_range(0, 599) == 0);
      if (c < 30)
        run_req = 1'b0;
      else if ($urandom_range(0, 149) == 0)
        run_req = ~run_req;
      if (c == 30) run_req = 1'b1;
      if (!(p_valid && !last_rdy)) begin
        rst_req_valid = ($urandom_range(0, 3) == 0);
        rst_req_voice = 3'($urandom_range(0, 7));
      end

      e.cyc  = c;
      e.slot = 6'(slot);
      e.fs   = (mode != 0) && (slot == 0);
      e.az   = (win >= 0) ? 8'(1 << win) : 8'h00;
      e.run  = (mode != 0);
      e.rdy  = !reset_reg && !pend[rst_req_voice] && (win != int'(rst_req_voice));
      e.fc   = 16'(m_fc);
      e.sc   = 16'(m_sc);
      last_fs  = e.fs;
      last_rdy = e.rdy;
      q.push_back(e);
    end
    @(negedge sCLK_XVXOSC);
    #2;
    check("queue_drained", -1, q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge sCLK_XVXOSC);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("xxxx",           e.cyc, 32'(xxxx),           32'(e.slot));
        check("frame_start",    e.cyc, 32'(frame_start),    32'(e.fs));
        check("osc_accum_zero", e.cyc, 32'(osc_accum_zero), 32'(e.az));
        check("running",        e.cyc, 32'(running),        32'(e.run));
        check("rst_req_ready",  e.cyc, 32'(rst_req_ready),  32'(e.rdy));
`ifdef OSC_SCHED_STATUS_EN
        check("frame_count",    e.cyc, 32'(frame_count),    32'(e.fc));
        check("stall_count",    e.cyc, 32'(stall_count),    32'(e.sc));
`endif
      end
    end
  end

endmodule
